// File: rtl/btb_predictor.sv
// btb_predictor
//    Direct-mapped branch target buffer with 2-bit saturating counters.
//    Fetch side: combinational lookup of if_pc against the registered table
//    yields pred_taken / pred_target for the next-PC select.
//    Resolve side: the EX/MEM outcome trains the table (write lands on the
//    next rising clk edge) and flags mispredicts with a corrective PC.
//
// Optional feature: define BTB_STATS_EN to build 32-bit hit and mispredict
//    counters on stat_hits / stat_mispred. Without it both ports read 0 and
//    no counter registers exist.
//
// Ports
//    clk             clock, all state changes on rising edge
//    rst             synchronous active-high reset
//    if_pc           fetch PC being looked up
//    pred_taken      lookup hit and counter predicts taken
//    pred_target     stored target if pred_taken, else if_pc+4
//    ex_valid        resolved instruction valid
//    ex_is_branch    resolved instruction is a conditional branch or jal
//    ex_pc           PC of the resolved instruction
//    ex_taken        actual outcome
//    ex_target       actual taken target
//    ex_pred_taken   prediction carried down the pipe
//    ex_pred_target  predicted target carried down the pipe
//    mispredict      redirect required this cycle
//    redirect_pc     correct next PC (meaningful only with mispredict)
//    stat_hits       lookup-hit count
//    stat_mispred    mispredict count
module btb_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] stat_hits,
   output logic [31:0] stat_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];

   logic [IDX_W-1:0]  if_idx;
   logic [TAG_W-1:0]  if_tag;
   logic [IDX_W-1:0]  ex_idx;
   logic [TAG_W-1:0]  ex_tag;
   logic              lookup_hit;
   logic              ex_hit;
   logic              upd;
   logic [1:0]        ctr_next;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[31:IDX_W+2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[31:IDX_W+2];

   // Gated by rst so the fetch side sees a cold table during the reset cycle.
   assign lookup_hit  = !rst && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = lookup_hit && ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

   assign upd    = ex_valid && ex_is_branch;
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   // Mispredict is purely a function of the resolve inputs; rst does not mask it.
   assign mispredict  = upd && ((ex_pred_taken != ex_taken) ||
                                (ex_taken && (ex_pred_target != ex_target)));
   assign redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

   always_comb begin
      ctr_next = ctr_q[ex_idx];
      if (ex_taken) begin
         if (ctr_q[ex_idx] != 2'b11) ctr_next = ctr_q[ex_idx] + 2'd1;
      end else begin
         if (ctr_q[ex_idx] != 2'b00) ctr_next = ctr_q[ex_idx] - 2'd1;
      end
   end

   // Lookup reads the old entry in the same cycle as a write; no bypass.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (upd) begin
         if (ex_hit) begin
            ctr_q[ex_idx] <= ctr_next;
            if (ex_taken) target_q[ex_idx] <= ex_target;
         end else if (ex_taken) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
            ctr_q[ex_idx]    <= 2'b10;
         end
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] hits_q;
   logic [31:0] mispred_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hits_q    <= '0;
         mispred_q <= '0;
      end else begin
         if (lookup_hit) hits_q    <= hits_q + 32'd1;
         if (mispredict) mispred_q <= mispred_q + 32'd1;
      end
   end

   assign stat_hits    = hits_q;
   assign stat_mispred = mispred_q;
`else
   assign stat_hits    = 32'd0;
   assign stat_mispred = 32'd0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] stat_hits;
   logic [31:0] stat_mispred;

   always #5 clk = ~clk;

   btb_predictor #(.ENTRIES(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .stat_hits      (stat_hits),
      .stat_mispred   (stat_mispred)
   );

   typedef struct {
      int          id;
      logic        pt;
      logic [31:0] tgt;
      logic        mis;
      logic [31:0] rdr;
      logic        chk_stats;
      logic [31:0] sh;
      logic [31:0] sm;
   } exp_t;

   exp_t        sb[$];
   logic        chk_en = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          vec_id = 0;
   logic [31:0] run_hits = 32'd0;
   logic [31:0] run_mis  = 32'd0;

   task automatic check(input string name, input int id, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, name, act, req);
      end
   endtask

   // Monitor: outputs are combinational, so every stimulus cycle presents
   // one observation, checked at the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pred_taken", e.id, {31'd0, pred_taken}, {31'd0, e.pt});
            check("pred_target", e.id, pred_target, e.tgt);
            check("mispredict", e.id, {31'd0, mispredict}, {31'd0, e.mis});
            if (e.mis) check("redirect_pc", e.id, redirect_pc, e.rdr);
            if (e.chk_stats) begin
               check("stat_hits", e.id, stat_hits, e.sh);
               check("stat_mispred", e.id, stat_mispred, e.sm);
            end
         end
      end
   end

   // One cycle: apply inputs, queue hand-computed expectations, advance.
   // hit = expected raw lookup hit (weak-counter hits included).
   task automatic cyc(input logic r, input logic [31:0] pc,
                      input logic ev, input logic eb, input logic [31:0] epc,
                      input logic et, input logic [31:0] etgt,
                      input logic ept, input logic [31:0] eptgt,
                      input logic x_pt, input logic [31:0] x_tgt,
                      input logic x_mis, input logic [31:0] x_rdr,
                      input logic hit);
      exp_t e;
      rst = r; if_pc = pc;
      ex_valid = ev; ex_is_branch = eb; ex_pc = epc; ex_taken = et;
      ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
      e.id = vec_id; e.pt = x_pt; e.tgt = x_tgt; e.mis = x_mis; e.rdr = x_rdr;
      e.chk_stats = !r;
`ifdef BTB_STATS_EN
      e.sh = run_hits; e.sm = run_mis;
`else
      e.sh = 32'd0; e.sm = 32'd0;
`endif
      sb.push_back(e);
      chk_en = 1'b1;
      if (r) begin
         run_hits = 32'd0; run_mis = 32'd0;
      end else begin
         if (hit)   run_hits = run_hits + 32'd1;
         if (x_mis) run_mis  = run_mis + 32'd1;
      end
      vec_id++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; if_pc = 32'h0; ex_valid = 1'b0; ex_is_branch = 1'b0;
      ex_pc = 32'h0; ex_taken = 1'b0; ex_target = 32'h0;
      ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
      @(posedge clk);
      #1;
      //   rst pc            ev eb ex_pc         tk tgt     ept eptgt     x_pt x_tgt          mis rdr          hit
      cyc(1, 32'h100,       0, 0, 32'h0,       0, 32'h0,   0, 32'h0,     0, 32'h104,        0, 32'h0,        0); // 0 reset cycle
      cyc(0, 32'h100,       1, 1, 32'h100,     0, 32'h0,   0, 32'h104,   0, 32'h104,        0, 32'h0,        0); // 1 NT miss, no alloc
      cyc(0, 32'h100,       1, 1, 32'h100,     1, 32'h200, 0, 32'h104,   0, 32'h104,        1, 32'h200,      0); // 2 alloc, same-cycle lookup sees old
      cyc(0, 32'h100,       1, 1, 32'h100,     1, 32'h200, 1, 32'h200,   1, 32'h200,        0, 32'h0,        1); // 3 ctr 10->11
      cyc(0, 32'h100,       1, 1, 32'h100,     1, 32'h200, 1, 32'h200,   1, 32'h200,        0, 32'h0,        1); // 4 ctr sat 11
      cyc(0, 32'h100,       1, 1, 32'h100,     0, 32'h0,   1, 32'h200,   1, 32'h200,        1, 32'h104,      1); // 5 ctr 11->10
      cyc(0, 32'h100,       1, 1, 32'h100,     0, 32'h0,   1, 32'h200,   1, 32'h200,        1, 32'h104,      1); // 6 ctr 10->01
      cyc(0, 32'h100,       1, 1, 32'h100,     0, 32'h0,   1, 32'h200,   0, 32'h104,        1, 32'h104,      1); // 7 weak NT hit, ctr->00
      cyc(0, 32'h140,       1, 0, 32'h140,     1, 32'h300, 0, 32'h0,     0, 32'h144,        0, 32'h0,        0); // 8 alias miss, non-branch
      cyc(0, 32'h140,       0, 1, 32'h140,     1, 32'h300, 0, 32'h0,     0, 32'h144,        0, 32'h0,        0); // 9 ex_valid=0
      cyc(0, 32'h140,       1, 1, 32'h140,     1, 32'h300, 0, 32'h144,   0, 32'h144,        1, 32'h300,      0); // 10 alias replaces entry
      cyc(0, 32'h100,       0, 0, 32'h0,       0, 32'h0,   0, 32'h0,     0, 32'h104,        0, 32'h0,        0); // 11 old PC misses
      cyc(0, 32'h140,       1, 1, 32'h140,     1, 32'h340, 1, 32'h300,   1, 32'h300,        1, 32'h340,      1); // 12 wrong target
      cyc(0, 32'h140,       0, 0, 32'h0,       0, 32'h0,   0, 32'h0,     1, 32'h340,        0, 32'h0,        1); // 13 target retrained
      cyc(1, 32'h140,       1, 1, 32'h100,     1, 32'h500, 0, 32'h104,   0, 32'h144,        1, 32'h500,      0); // 14 rst with update
      cyc(0, 32'h100,       0, 0, 32'h0,       0, 32'h0,   0, 32'h0,     0, 32'h104,        0, 32'h0,        0); // 15 dropped update
      cyc(0, 32'h140,       0, 0, 32'h0,       0, 32'h0,   0, 32'h0,     0, 32'h144,        0, 32'h0,        0); // 16 cleared by rst
      cyc(0, 32'hFFFFFFFC,  1, 1, 32'hFFFFFFFC,0, 32'h0,   1, 32'h10,    0, 32'h0,          1, 32'h0,        0); // 17 +4 wraps
      cyc(0, 32'hFFFFFFFC,  0, 0, 32'h0,       0, 32'h0,   0, 32'h0,     0, 32'h0,          0, 32'h0,        0); // 18 no alloc on NT
      chk_en = 1'b0;
      ex_valid = 1'b0; ex_is_branch = 1'b0;
      repeat (2) @(posedge clk);
      check("scoreboard_drained", -1, sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating counters.
- At fetch it produces the predicted next PC, which feeds the next-PC select as the hit choice. At EX/MEM it receives the resolved branch outcome, updates the table, and flags mispredicts with the corrective redirect PC.
- This is the write/train side of the prediction path; the fetch-side PC select only consumes its outputs.

Parameters:
- ENTRIES, 16, number of table entries (power of 2, 4..256)
- IDX_W, $clog2(ENTRIES), index width (derived; do not override)
- TAG_W, 30-IDX_W, tag width (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- if_pc  in  32  fetch PC being looked up
- pred_taken  out  1  lookup hit and counter[1]==1
- pred_target  out  32  predicted next PC: stored target if pred_taken, else if_pc+4
- ex_valid  in  1  resolved instruction valid this cycle
- ex_is_branch  in  1  instruction is a conditional branch or jal
- ex_pc  in  32  PC of the resolved instruction
- ex_taken  in  1  actual outcome
- ex_target  in  32  actual taken target
- ex_pred_taken  in  1  pred_taken carried down the pipe with this instruction
- ex_pred_target  in  32  pred_target carried down the pipe with this instruction
- mispredict  out  1  redirect required this cycle
- redirect_pc  out  32  correct next PC: ex_taken ? ex_target : ex_pc+4
- stat_hits  out  32  lookup-hit count (optional feature)
- stat_mispred  out  32  mispredict count (optional feature)

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] is ignored.
- Entry contents: valid, tag, target[31:0], ctr[1:0].
- Lookup is combinational from the registered table (zero latency). hit = valid && tag match.
- Update write enable: upd = ex_valid && ex_is_branch. The write lands at the next rising edge.
- On hit:
  - ctr increments if ex_taken, saturating at 3; decrements if not taken, saturating at 0.
  - target := ex_target if ex_taken, otherwise unchanged.
- On miss and ex_taken: allocate, replacing whatever is there. valid=1, tag, target=ex_target, ctr=2'b10.
- On miss and not taken: no write.
- mispredict (combinational) = upd && ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target)).
  - ex_valid=0 or ex_is_branch=0 forces mispredict=0.
  - redirect_pc is always driven and is meaningful only when mispredict=1.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update (old) entry. There is no write-through bypass.
- Reset (any cycle, including mid-update):
  - all valid bits cleared; all ctr set to 2'b01; targets and tags don't-care.
  - An update presented in the reset cycle is dropped.
  - Outputs during and after reset: pred_taken=0, pred_target=if_pc+4. mispredict follows its inputs; it is not gated by rst.
- Arithmetic: all +4 additions are 32-bit and wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
- Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Predict taken iff ctr[1]==1.

Optional Feature:
- Macro: BTB_STATS_EN.
- When defined:
  - stat_hits increments every cycle that a lookup hits.
  - stat_mispred increments every cycle that mispredict=1.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- When undefined: both ports are tied to 0 and no counter registers are built. Prediction behaviour is identical in both builds.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; update ex_pc=0x100 not-taken, ex_pred_taken=0 -> mispredict=0, no allocation.
- Update ex_pc=0x100, ex_taken=1, ex_target=0x200, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x200; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x200.
- Training at 0x100 after allocation:
  - 2 more taken updates -> ctr=11.
  - 1 not-taken -> ctr=10, still predicts 0x200.
  - 2nd not-taken -> ctr=01, pred_target=0x104.
  - Not-taken with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x104.
- Aliasing with ENTRIES=16: after allocating 0x100, lookup 0x140 -> miss, 0x144. Taken update at 0x140 with target 0x300 replaces the entry, so 0x100 now misses.
- Same-cycle conflict and reset:
  - Update allocating 0x100 while if_pc=0x100 in the same cycle -> pred_taken=0 that cycle, 1 the next.
  - rst pulse -> lookup 0x100 misses.
- With BTB_STATS_EN: 3 hit cycles and 2 mispredicts -> stat_hits=3, stat_mispred=2; rst -> both 0. Without the macro both read 0 throughout.
